// File: rtl/xosera_bus_master_pkg.sv
// xosera_bus_master_pkg
//   Shared definitions for the Xosera host-bus master: FSM state encoding,
//   default bus timing constants and a small helper for sizing the phase
//   counter.
package xosera_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } bm_state_t;

    localparam int DEF_SETUP_CYCLES  = 2;
    localparam int DEF_STROBE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES   = 1;
    localparam int DEF_SAMPLE_CYCLE  = 2;
    localparam int DEF_REG_BITS      = 4;

    // Largest of the three phase lengths; sizes the shared down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/xosera_bus_phase_timer.sv
// xosera_bus_phase_timer
//   Loadable down-counter that times one bus phase. Loading N-1 gives a
//   phase of N cycles; last_o is high in the final cycle of the phase.
// Ports
//   clk         system clock
//   reset_i     synchronous active-high reset
//   load_i      reload the counter with load_val_i at this edge
//   load_val_i  phase length minus one
//   cnt_o       current remaining count (N-1 down to 0)
//   last_o      final cycle of the current phase
module xosera_bus_phase_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/xosera_bus_master.sv
// xosera_bus_master
//   Turns queued register commands into Xosera 8-bit host bus cycles with
//   programmable setup / strobe / hold timing. Word commands are issued as
//   the high byte then the low byte; reads return the assembled 16-bit value.
// Ports
//   clk, reset_i              clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake (accept on valid && ready)
//   cmd_rd_i, cmd_word_i      read/write select, word/byte select
//   cmd_bytesel_i             byte lane for byte commands (0=high, 1=low)
//   cmd_reg_i, cmd_data_i     target register and write data
//   done_o, rsp_data_o        completion pulse and read data (0 for writes)
//   bus_*_o, bus_data_i       Xosera host bus
module xosera_bus_master
    import xosera_bus_master_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int SAMPLE_CYCLE  = DEF_SAMPLE_CYCLE,
    parameter int REG_BITS      = DEF_REG_BITS
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_rd_i,
    input  logic                cmd_word_i,
    input  logic                cmd_bytesel_i,
    input  logic [REG_BITS-1:0] cmd_reg_i,
    input  logic [15:0]         cmd_data_i,
    output logic                done_o,
    output logic [15:0]         rsp_data_o,
    output logic                bus_cs_n_o,
    output logic                bus_rd_nwr_o,
    output logic                bus_bytesel_o,
    output logic [REG_BITS-1:0] bus_reg_num_o,
    output logic [7:0]          bus_data_o,
    input  logic [7:0]          bus_data_i
);

    localparam int CW = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) + 1);

    // Strobe index counts up while the timer counts down, so the capture
    // point is expressed as the remaining count at that index.
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(STROBE_CYCLES - 1 - SAMPLE_CYCLE);

    bm_state_t       state_q, state_d;
    logic            tmr_load;
    logic [CW-1:0]   tmr_load_val;
    logic [CW-1:0]   tmr_cnt;
    logic            tmr_last;

    logic            accept;
    logic            last_byte;
    logic            sample_hit;
    logic            finish;

    // latched command
    logic            rd_q;
    logic            word_q;
    logic            phase_q;
    logic [7:0]      lo_q;
    logic [15:0]     rdata_q;

    // outputs
    logic            done_q;
    logic [15:0]     rsp_q;
    logic            rd_nwr_q;
    logic            bytesel_q;
    logic [REG_BITS-1:0] reg_q;
    logic [7:0]      wdata_q;

    assign accept     = cmd_valid_i && (state_q == ST_IDLE);
    assign last_byte  = !word_q || phase_q;
    assign sample_hit = (state_q == ST_STROBE) && (tmr_cnt == SAMPLE_CNT);
    assign finish     = (state_q == ST_HOLD) && tmr_last && last_byte;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_load_val = '0;
        unique case (state_q)
            ST_IDLE:   if (accept)   state_d = ST_SETUP;
            ST_SETUP:  if (tmr_last) state_d = ST_STROBE;
            ST_STROBE: if (tmr_last) state_d = ST_HOLD;
            ST_HOLD:   if (tmr_last) state_d = last_byte ? ST_IDLE : ST_SETUP;
            default:   state_d = ST_IDLE;
        endcase
        // Every state change restarts the timer with the new phase length.
        tmr_load = (state_d != state_q);
        unique case (state_d)
            ST_SETUP:  tmr_load_val = CW'(SETUP_CYCLES - 1);
            ST_STROBE: tmr_load_val = CW'(STROBE_CYCLES - 1);
            ST_HOLD:   tmr_load_val = CW'(HOLD_CYCLES - 1);
            default:   tmr_load_val = '0;
        endcase
    end

    xosera_bus_phase_timer #(
        .CW(CW)
    ) u_timer (
        .clk        (clk),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .cnt_o      (tmr_cnt),
        .last_o     (tmr_last)
    );

    always_ff @(posedge clk) begin
        if (reset_i) begin
            rd_q      <= 1'b0;
            word_q    <= 1'b0;
            phase_q   <= 1'b0;
            lo_q      <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            rsp_q     <= '0;
            rd_nwr_q  <= 1'b1;
            bytesel_q <= 1'b0;
            reg_q     <= '0;
            wdata_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                rd_q      <= cmd_rd_i;
                word_q    <= cmd_word_i;
                phase_q   <= 1'b0;
                lo_q      <= cmd_data_i[7:0];
                rdata_q   <= '0;     // unused lane of a byte read reads as 0
                rd_nwr_q  <= cmd_rd_i;
                bytesel_q <= cmd_word_i ? 1'b0 : cmd_bytesel_i;
                reg_q     <= cmd_reg_i;
                wdata_q   <= cmd_word_i ? cmd_data_i[15:8] : cmd_data_i[7:0];
            end
            if (sample_hit) begin
                if (!bytesel_q) rdata_q[15:8] <= bus_data_i;
                else            rdata_q[7:0]  <= bus_data_i;
            end
            if (finish) begin
                done_q   <= 1'b1;
                rsp_q    <= rd_q ? rdata_q : 16'h0000;
                rd_nwr_q <= 1'b1;    // never leave a write asserted while idle
            end else if ((state_q == ST_HOLD) && tmr_last) begin
                // second half of a word: switch to the low byte lane
                phase_q   <= 1'b1;
                bytesel_q <= 1'b1;
                wdata_q   <= lo_q;
            end
        end
    end

    assign cmd_ready_o   = (state_q == ST_IDLE);
    assign done_o        = done_q;
    assign rsp_data_o    = rsp_q;
    assign bus_cs_n_o    = (state_q != ST_STROBE);
    assign bus_rd_nwr_o  = rd_nwr_q;
    assign bus_bytesel_o = bytesel_q;
    assign bus_reg_num_o = reg_q;
    assign bus_data_o    = wdata_q;

endmodule

// File: tb/tb_xosera_bus_master.sv
// tb_xosera_bus_master
//   Randomized bench for xosera_bus_master. Two instances share the command
//   and slave-data inputs: u_dut0 uses default timing, u_dut1 a one-cycle
//   strobe sampling at index 0. `sel` picks which one is driven/observed.
//   The reference model predicts each bus cycle from the command's phase
//   arithmetic (setup/strobe/hold lengths) and the slave bytes it supplies.
module tb_xosera_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic        sel;
    logic        cmd_valid;
    logic        cmd_rd, cmd_word, cmd_bytesel;
    logic [3:0]  cmd_reg;
    logic [15:0] cmd_data;
    logic [7:0]  bus_data_i;

    logic        rdy0, done0, cs0, rdn0, bs0, rdy1, done1, cs1, rdn1, bs1;
    logic [15:0] rsp0, rsp1;
    logic [3:0]  reg0, reg1;
    logic [7:0]  dat0, dat1;

    xosera_bus_master u_dut0 (
        .clk(clk), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid && !sel), .cmd_ready_o(rdy0),
        .cmd_rd_i(cmd_rd), .cmd_word_i(cmd_word), .cmd_bytesel_i(cmd_bytesel),
        .cmd_reg_i(cmd_reg), .cmd_data_i(cmd_data),
        .done_o(done0), .rsp_data_o(rsp0),
        .bus_cs_n_o(cs0), .bus_rd_nwr_o(rdn0), .bus_bytesel_o(bs0),
        .bus_reg_num_o(reg0), .bus_data_o(dat0), .bus_data_i(bus_data_i)
    );

    xosera_bus_master #(
        .SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .SAMPLE_CYCLE(0), .REG_BITS(4)
    ) u_dut1 (
        .clk(clk), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid && sel), .cmd_ready_o(rdy1),
        .cmd_rd_i(cmd_rd), .cmd_word_i(cmd_word), .cmd_bytesel_i(cmd_bytesel),
        .cmd_reg_i(cmd_reg), .cmd_data_i(cmd_data),
        .done_o(done1), .rsp_data_o(rsp1),
        .bus_cs_n_o(cs1), .bus_rd_nwr_o(rdn1), .bus_bytesel_o(bs1),
        .bus_reg_num_o(reg1), .bus_data_o(dat1), .bus_data_i(bus_data_i)
    );

    logic        m_rdy, m_done, m_cs, m_rdn, m_bs;
    logic [15:0] m_rsp;
    logic [3:0]  m_reg;
    logic [7:0]  m_dat;
    assign m_rdy  = sel ? rdy1  : rdy0;
    assign m_done = sel ? done1 : done0;
    assign m_cs   = sel ? cs1   : cs0;
    assign m_rdn  = sel ? rdn1  : rdn0;
    assign m_bs   = sel ? bs1   : bs0;
    assign m_rsp  = sel ? rsp1  : rsp0;
    assign m_reg  = sel ? reg1  : reg0;
    assign m_dat  = sel ? dat1  : dat0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] last_rsp = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // idle cycles: bus parked, ready, no completion, response held
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_data_i = 8'($urandom);
            chk("idle_rdy",  m_rdy,  1);
            chk("idle_done", m_done, 0);
            chk("idle_cs",   m_cs,   1);
            chk("idle_rdn",  m_rdn,  1);
            chk("idle_rsp",  m_rsp,  last_rsp);
        end
    endtask

    // Issue one command at the current negedge (cycle 0) and follow it until
    // its completion cycle. Returns at the negedge of the done cycle so the
    // next call can present a back-to-back command.
    task automatic run_cmd(input logic rd, input logic word, input logic bs,
                           input logic [3:0] rg, input logic [15:0] d,
                           input logic [7:0] sb0, input logic [7:0] sb1);
        int S, T, H, SM, P, nb, lat, p, k;
        logic        strobe;
        logic [7:0]  sb;
        logic [15:0] exp_rsp;
        S = 2; H = 1;
        T  = sel ? 1 : 4;
        SM = sel ? 0 : 2;
        P   = S + T + H;
        nb  = word ? 2 : 1;
        lat = 1 + nb * P;
        if (!rd)       exp_rsp = 16'h0000;
        else if (word) exp_rsp = {sb0, sb1};
        else if (bs)   exp_rsp = {8'h00, sb0};
        else           exp_rsp = {sb0, 8'h00};

        chk("accept_rdy", m_rdy, 1);
        cmd_valid = 1'b1; cmd_rd = rd; cmd_word = word; cmd_bytesel = bs;
        cmd_reg = rg; cmd_data = d;
        for (int o = 1; o <= lat; o++) begin
            @(negedge clk);
            if (o == 1) begin
                // scramble the command inputs: the DUT must use its latched copy
                cmd_valid = 1'b0; cmd_rd = 1'($urandom); cmd_word = 1'($urandom);
                cmd_bytesel = 1'($urandom); cmd_reg = 4'($urandom); cmd_data = 16'($urandom);
            end
            if (o < lat) begin
                p = (o - 1) / P;
                k = (o - 1) % P;
                strobe = (k >= S) && (k < S + T);
                sb = (p == 0) ? sb0 : sb1;
                chk("cs_n",    m_cs,   !strobe);
                chk("busy",    m_rdy,  0);
                chk("no_done", m_done, 0);
                chk("rd_nwr",  m_rdn,  rd);
                chk("bytesel", m_bs,   word ? p[0] : bs);
                chk("reg",     m_reg,  rg);
                if (!rd) chk("wdata", m_dat, word ? ((p == 0) ? d[15:8] : d[7:0]) : d[7:0]);
                // only the sample-point cycle carries the real byte
                bus_data_i = (strobe && (k - S) == SM) ? sb : ~sb;
            end else begin
                bus_data_i = 8'($urandom);
                chk("done",      m_done, 1);
                chk("rsp",       m_rsp,  exp_rsp);
                chk("done_rdy",  m_rdy,  1);
                chk("done_cs",   m_cs,   1);
                chk("done_rdn",  m_rdn,  1);
            end
        end
        last_rsp = exp_rsp;
    endtask

    task automatic rand_cmd();
        run_cmd(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                16'($urandom), 8'($urandom), 8'($urandom));
    endtask

    initial begin
        reset_i = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_word = 1'b0;
        cmd_bytesel = 1'b0; cmd_reg = '0; cmd_data = '0; bus_data_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy",   m_rdy,  1);
        chk("rst_done",  m_done, 0);
        chk("rst_rsp",   m_rsp,  0);
        chk("rst_cs",    m_cs,   1);
        chk("rst_rdn",   m_rdn,  1);
        chk("rst_bs",    m_bs,   0);
        chk("rst_reg",   m_reg,  0);
        chk("rst_dat",   m_dat,  0);
        reset_i = 1'b0;
        idle(1);

        // directed: byte write, word write, word read, back-to-back bytes
        run_cmd(1'b0, 1'b0, 1'b1, 4'd3, 16'h005A, 8'h00, 8'h00);
        idle(1);
        run_cmd(1'b0, 1'b1, 1'b0, 4'd1, 16'hBEEF, 8'h00, 8'h00);
        idle(2);
        run_cmd(1'b1, 1'b1, 1'b0, 4'd2, 16'h0000, 8'hAB, 8'hCD);
        idle(1);
        run_cmd(1'b0, 1'b0, 1'b0, 4'd7, 16'h0011, 8'h00, 8'h00);
        run_cmd(1'b1, 1'b0, 1'b0, 4'd8, 16'h0000, 8'h3C, 8'h00);
        idle(1);

        // random mix with random idle gaps (including none)
        for (int i = 0; i < 40; i++) begin
            rand_cmd();
            idle(int'($urandom_range(0, 2)));
        end

        // reset in the middle of a strobe drops the command
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_word = 1'b1; cmd_bytesel = 1'b0;
        cmd_reg = 4'd9; cmd_data = 16'h1234;
        for (int o = 1; o <= 4; o++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        chk("mid_cs", m_cs, 0);
        reset_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_cs",   m_cs,   1);
        chk("rst_mid_done", m_done, 0);
        reset_i = 1'b0;
        last_rsp = 16'h0000;
        idle(4);

        // one-cycle strobe instance, sampling at index 0
        sel = 1'b1;
        idle(1);
        run_cmd(1'b1, 1'b0, 1'b1, 4'd5, 16'h0000, 8'h77, 8'h00);
        idle(1);
        for (int i = 0; i < 15; i++) begin
            rand_cmd();
            idle(int'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
